// File: rtl/biriscv_mule.sv
// Iterative 32x32 multiplier for MUL/MULH/MULHSU/MULHU.
// Radix-2 shift-add, fixed 33-cycle issue-to-result latency.
module biriscv_mule (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        mule_complete_o,
  output logic [31:0] mule_result_o,
  output logic [4:0]  mule_rd_idx_o
);

  localparam logic [31:0] INST_MUL         = 32'h02000033;
  localparam logic [31:0] INST_MUL_MASK    = 32'hfe00707f;
  localparam logic [31:0] INST_MULH        = 32'h02001033;
  localparam logic [31:0] INST_MULH_MASK   = 32'hfe00707f;
  localparam logic [31:0] INST_MULHSU      = 32'h02002033;
  localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00707f;
  localparam logic [31:0] INST_MULHU       = 32'h02003033;
  localparam logic [31:0] INST_MULHU_MASK  = 32'hfe00707f;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  count_q;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [2:0]  funct3_q;
  logic        sign_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  logic        is_mul;
  logic        is_mulh;
  logic        is_mulhsu;
  logic        is_mulhu;
  logic        match;
  logic        accept;
  logic [2:0]  funct3;
  logic        signed_a;
  logic        signed_b;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc_next;
  logic [63:0] product;
  logic        last;

  always_comb begin
    is_mul    = (opcode_opcode_i & INST_MUL_MASK) == INST_MUL;
    is_mulh   = (opcode_opcode_i & INST_MULH_MASK) == INST_MULH;
    is_mulhsu = (opcode_opcode_i & INST_MULHSU_MASK) == INST_MULHSU;
    is_mulhu  = (opcode_opcode_i & INST_MULHU_MASK) == INST_MULHU;
    match     = is_mul | is_mulh | is_mulhsu | is_mulhu;
    accept    = rst_ni & opcode_valid_i & match
              & (state_q == IDLE) & ~hold_i & ~flush_i;
  end

  always_comb begin
    funct3   = opcode_opcode_i[14:12];
    signed_a = is_mulh | is_mulhsu;
    signed_b = is_mulh;
    a_neg    = signed_a & opcode_ra_operand_i[31];
    b_neg    = signed_b & opcode_rb_operand_i[31];
    a_mag    = a_neg ? (~opcode_ra_operand_i + 32'd1)
                     : opcode_ra_operand_i;
    b_mag    = b_neg ? (~opcode_rb_operand_i + 32'd1)
                     : opcode_rb_operand_i;
  end

  // Final add is folded in so the sign fix-up sees the full product.
  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    product  = sign_q ? (~acc_next + 64'd1) : acc_next;
    last     = (state_q == CALC) && (count_q == 5'd0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = CALC;
      end
      CALC: begin
        if (flush_i)
          state_d = IDLE;
        else if (count_q == 5'd0)
          state_d = DONE;
      end
      DONE: begin
        if (flush_i || !hold_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 5'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      funct3_q <= 3'd0;
      sign_q   <= 1'b0;
      rd_q     <= 5'd0;
    end else if (accept) begin
      count_q  <= 5'd31;
      acc_q    <= 64'd0;
      mcand_q  <= {32'd0, a_mag};
      mplier_q <= b_mag;
      funct3_q <= funct3;
      sign_q   <= a_neg ^ b_neg;
      rd_q     <= opcode_rd_idx_i;
    end else if (state_q == CALC && !flush_i) begin
      count_q  <= count_q - 5'd1;
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else if (last && !flush_i) begin
      result_q <= (funct3_q == 3'b000) ? product[31:0]
                                       : product[63:32];
      rd_out_q <= rd_q;
    end
  end

  always_comb begin
    stall_o         = accept
                    | (state_q == CALC)
                    | ((state_q == DONE) & hold_i);
    mule_complete_o = (state_q == DONE);
    mule_result_o   = result_q;
    mule_rd_idx_o   = rd_out_q;
  end

endmodule

// File: tb/tb_biriscv_mule.sv
// Bench for biriscv_mule: cycle-level reference model
// compared every cycle, plus directed literal checks.
module tb_biriscv_mule;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        opcode_valid_i = 1'b0;
  logic [31:0] opcode_opcode_i = 32'd0;
  logic [4:0]  opcode_rd_idx_i = 5'd0;
  logic [31:0] opcode_ra_operand_i = 32'd0;
  logic [31:0] opcode_rb_operand_i = 32'd0;
  logic        hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        mule_complete_o;
  logic [31:0] mule_result_o;
  logic [4:0]  mule_rd_idx_o;

  biriscv_mule dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .opcode_valid_i      (opcode_valid_i),
    .opcode_opcode_i     (opcode_opcode_i),
    .opcode_rd_idx_i     (opcode_rd_idx_i),
    .opcode_ra_operand_i (opcode_ra_operand_i),
    .opcode_rb_operand_i (opcode_rb_operand_i),
    .hold_i              (hold_i),
    .flush_i             (flush_i),
    .stall_o             (stall_o),
    .mule_complete_o     (mule_complete_o),
    .mule_result_o       (mule_result_o),
    .mule_rd_idx_o       (mule_rd_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    sa = (f3 == 3'd1 || f3 == 3'd2) ? longint'($signed(a))
                                    : longint'({32'd0, a});
    sb = (f3 == 3'd1) ? longint'($signed(b))
                      : longint'({32'd0, b});
    p = sa * sb;
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mk_op(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd0, 7'b0110011};
  endfunction

  function automatic logic is_mul_op(input logic [31:0] op);
    return op[6:0] == 7'b0110011 && op[31:25] == 7'b0000001
        && op[14] == 1'b0;
  endfunction

  // Reference model: an op is either computing (started at
  // cycle t0) or presenting its result, else the unit is free.
  logic        m_busy = 1'b0;
  logic        m_pres = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  logic [2:0]  p_f3 = 3'd0;
  logic [31:0] p_a = 32'd0;
  logic [31:0] p_b = 32'd0;
  logic [4:0]  p_rd = 5'd0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;

  function automatic logic m_accept();
    return rst_ni && opcode_valid_i && is_mul_op(opcode_opcode_i)
        && !m_busy && !m_pres && !hold_i && !flush_i;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 1'b0;
      m_pres = 1'b0;
      m_res  = 32'd0;
      m_rd   = 5'd0;
    end else begin
      if (m_pres) begin
        if (flush_i || !hold_i) m_pres = 1'b0;
      end else if (m_busy) begin
        if (flush_i) begin
          m_busy = 1'b0;
        end else if (cyc - t0 == 32) begin
          m_busy = 1'b0;
          m_pres = 1'b1;
          m_res  = mul_ref(p_f3, p_a, p_b);
          m_rd   = p_rd;
        end
      end else if (m_accept()) begin
        m_busy = 1'b1;
        t0     = cyc;
        p_f3   = opcode_opcode_i[14:12];
        p_a    = opcode_ra_operand_i;
        p_b    = opcode_rb_operand_i;
        p_rd   = opcode_rd_idx_i;
      end
      cyc++;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("m_stall", {31'd0, stall_o},
            {31'd0, m_accept() | m_busy | (m_pres & hold_i)});
      check("m_cmpl", {31'd0, mule_complete_o}, {31'd0, m_pres});
      check("m_res", mule_result_o, m_res);
      check("m_rd", {27'd0, mule_rd_idx_o}, {27'd0, m_rd});
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd);
    opcode_valid_i      = 1'b1;
    opcode_opcode_i     = op;
    opcode_ra_operand_i = a;
    opcode_rb_operand_i = b;
    opcode_rd_idx_i     = rd;
  endtask

  // Issue at cycle T, check busy window, result at T+33,
  // then return at the start of T+34.
  task automatic run_op(input string nm,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp);
    issue(mk_op(f3), a, b, rd);
    @(negedge clk_i);
    check({nm, "_stall_acc"}, {31'd0, stall_o}, 32'd1);
    step();
    opcode_valid_i = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      if (!stall_o || mule_complete_o) begin
        check({nm, "_busy"},
              {30'd0, stall_o, mule_complete_o}, 32'd2);
      end
      step();
    end
    @(negedge clk_i);
    check({nm, "_cmpl"}, {31'd0, mule_complete_o}, 32'd1);
    check({nm, "_res"}, mule_result_o, exp);
    check({nm, "_rd"}, {27'd0, mule_rd_idx_o}, {27'd0, rd});
    check({nm, "_stall_done"}, {31'd0, stall_o}, 32'd0);
    step();
  endtask

  initial begin
    check("ref_mul", mul_ref(3'd0, 32'd7, 32'd6), 32'd42);
    check("ref_mulh", mul_ref(3'd1, 32'hffffffff, 32'hffffffff),
          32'h00000000);
    check("ref_mulhu", mul_ref(3'd3, 32'hffffffff, 32'hffffffff),
          32'hfffffffe);
    check("ref_mulhsu", mul_ref(3'd2, 32'hffffffff, 32'hffffffff),
          32'hffffffff);
    check("ref_mulh80", mul_ref(3'd1, 32'h80000000, 32'h80000000),
          32'h40000000);

    repeat (3) @(posedge clk_i);
    #1;
    chk_en = 1'b1;
    @(negedge clk_i);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_cmpl", {31'd0, mule_complete_o}, 32'd0);
    check("rst_res", mule_result_o, 32'd0);
    check("rst_rd", {27'd0, mule_rd_idx_o}, 32'd0);
    step();
    rst_ni = 1'b1;

    run_op("mul76", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42);
    @(negedge clk_i);
    check("mul76_cmpl_end", {31'd0, mule_complete_o}, 32'd0);
    check("mul76_res_hold", mule_result_o, 32'd42);
    step();

    run_op("mulh_ff", 3'd1, 32'hffffffff, 32'hffffffff, 5'd6,
           32'h00000000);
    run_op("mulhu_ff", 3'd3, 32'hffffffff, 32'hffffffff, 5'd7,
           32'hfffffffe);
    run_op("mulhsu_ff", 3'd2, 32'hffffffff, 32'hffffffff, 5'd8,
           32'hffffffff);
    run_op("mul_80", 3'd0, 32'h80000000, 32'h80000000, 5'd9,
           32'h00000000);
    run_op("mulh_80", 3'd1, 32'h80000000, 32'h80000000, 5'd10,
           32'h40000000);

    // Hold at completion, with an ADD offered mid-calculation.
    issue(mk_op(3'd0), 32'd5, 32'd5, 5'd11);
    step();
    opcode_valid_i = 1'b0;
    repeat (9) step();
    issue(32'h00208033, 32'd1, 32'd2, 5'd12);
    @(negedge clk_i);
    check("hold_add_stall", {31'd0, stall_o}, 32'd1);
    step();
    opcode_valid_i = 1'b0;
    repeat (22) step();
    hold_i = 1'b1;
    for (int k = 33; k <= 35; k++) begin
      @(negedge clk_i);
      check("hold_cmpl", {31'd0, mule_complete_o}, 32'd1);
      check("hold_stall", {31'd0, stall_o}, 32'd1);
      check("hold_res", mule_result_o, 32'd25);
      step();
    end
    hold_i = 1'b0;
    @(negedge clk_i);
    check("hold_rel_stall", {31'd0, stall_o}, 32'd0);
    step();
    @(negedge clk_i);
    check("hold_idle_cmpl", {31'd0, mule_complete_o}, 32'd0);
    check("hold_rd", {27'd0, mule_rd_idx_o}, 32'd11);
    step();

    // Flush mid-calculation.
    issue(mk_op(3'd0), 32'd4, 32'd4, 5'd13);
    step();
    opcode_valid_i = 1'b0;
    repeat (14) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    check("flush_cmpl", {31'd0, mule_complete_o}, 32'd0);
    check("flush_res", mule_result_o, 32'd25);
    step();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk_i);
      if (mule_complete_o)
        check("flush_no_cmpl", {31'd0, mule_complete_o}, 32'd0);
      step();
    end
    run_op("mul33", 3'd0, 32'd3, 32'd3, 5'd3, 32'd9);

    // Reset mid-calculation.
    issue(mk_op(3'd0), 32'd7, 32'd7, 5'd4);
    step();
    opcode_valid_i = 1'b0;
    repeat (19) step();
    rst_ni = 1'b0;
    #1;
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    check("arst_cmpl", {31'd0, mule_complete_o}, 32'd0);
    check("arst_res", mule_result_o, 32'd0);
    check("arst_rd", {27'd0, mule_rd_idx_o}, 32'd0);
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (mule_complete_o)
        check("arst_no_cmpl", {31'd0, mule_complete_o}, 32'd0);
      step();
    end
    run_op("mul23", 3'd0, 32'd2, 32'd3, 5'd1, 32'd6);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
